// File: rtl/btn_press_classifier.sv
// Button press classifier: turns press/release edge pulses into short-press,
// long-press and double-click events. Auto-repeat is enabled by BTN_PRESS_REPEAT_EN.
module btn_press_classifier #(
    parameter int LONG_CYCLES    = 100_000_000,
    parameter int DBL_GAP_CYCLES = 30_000_000,
    parameter int REPEAT_CYCLES  = 20_000_000
) (
    input  logic clk,
    input  logic reset_p,
    input  logic p_edge,
    input  logic n_edge,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic held
);

    localparam int MAX_AB = (LONG_CYCLES > DBL_GAP_CYCLES) ? LONG_CYCLES : DBL_GAP_CYCLES;
    localparam int MAX_C  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_C);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HELD = 3'd2,
        WAIT2     = 3'd3,
        PRESS2    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          dbl_q, dbl_d;
    logic          held_q, held_d;
    logic          rep_hit;

    // Simultaneous press and release cancel each other out.
    logic p_ev, n_ev;
    assign p_ev = p_edge & ~n_edge;
    assign n_ev = n_edge & ~p_edge;

`ifdef BTN_PRESS_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
    logic rep_q;
    assign rep_hit      = (state_q == LONG_HELD) && !n_ev && (cnt_q == REP_LAST);
    assign repeat_pulse = rep_q;
`else
    assign rep_hit      = 1'b0;
    assign repeat_pulse = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            held_q  <= 1'b0;
`ifdef BTN_PRESS_REPEAT_EN
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            held_q  <= held_d;
`ifdef BTN_PRESS_REPEAT_EN
            rep_q   <= rep_hit;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (p_ev) state_d = PRESS1;
            PRESS1: begin
                if (n_ev)                    state_d = WAIT2;
                else if (cnt_q == LONG_LAST) state_d = LONG_HELD;
            end
            LONG_HELD: if (n_ev) state_d = IDLE;
            WAIT2: begin
                if (p_ev)                   state_d = PRESS2;
                else if (cnt_q == DBL_LAST) state_d = IDLE;
            end
            PRESS2:    if (n_ev) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Counter restarts on every state change; it only runs in timed states.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q) begin
            case (state_q)
                PRESS1, WAIT2: cnt_d = cnt_q + CW'(1);
`ifdef BTN_PRESS_REPEAT_EN
                LONG_HELD:     cnt_d = rep_hit ? '0 : cnt_q + CW'(1);
`endif
                default:       cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        short_d = (state_q == WAIT2)  && (state_d == IDLE);
        long_d  = (state_q == PRESS1) && (state_d == LONG_HELD);
        dbl_d   = (state_q == WAIT2)  && (state_d == PRESS2);
        held_d  = (state_d == PRESS1) || (state_d == LONG_HELD) || (state_d == PRESS2);
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign held         = held_q;

endmodule

// File: doc/btn_press_classifier.md
# btn_press_classifier

Classifies button activity into short-press, long-press and double-click events, with optional auto-repeat while held. It sits directly downstream of the button edge detector and consumes its single-cycle `p_edge`/`n_edge` pulses. Its outputs drive mode/set logic in the clock and sensor front panel.

## Interface
Parameters:
- `LONG_CYCLES`, default 100_000_000: clk cycles a press must last to count as long (1 s at 100 MHz). Must be ≥2.
- `DBL_GAP_CYCLES`, default 30_000_000: maximum release-to-press gap, in clk cycles, that still counts as a double click. Must be ≥2.
- `REPEAT_CYCLES`, default 20_000_000: auto-repeat period after a long press. Must be ≥2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_p`  in  1  reset: asynchronous, active-high.
- `p_edge`  in  1  one-cycle press pulse from the edge detector.
- `n_edge`  in  1  one-cycle release pulse from the edge detector.
- `short_press`  out  1  one-cycle pulse for a single short press.
- `long_press`  out  1  one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `double_click`  out  1  one-cycle pulse on the second press of a double click.
- `repeat_pulse`  out  1  one-cycle auto-repeat pulse; constant 0 without the macro.
- `held`  out  1  level; 1 while the FSM considers the button pressed.

## Operation
- All outputs are registered. Every output resets to 0. State resets to `IDLE`; the counter resets to 0.
- Internal counter width is `$clog2` of the largest parameter. The counter clears on every state change and never wraps.
- `p_edge` and `n_edge` high in the same cycle: both are ignored and treated as no event.

State machine:
- `IDLE`
  - `p_edge` → `PRESS1`.
  - `n_edge` is ignored.
- `PRESS1` (`held`=1), counter increments each cycle.
  - `n_edge` → `WAIT2`.
  - Otherwise, counter = `LONG_CYCLES`-1 → `long_press` pulse, go to `LONG_HELD`.
  - `n_edge` has priority over the long-press limit on the same edge.
- `LONG_HELD` (`held`=1)
  - `n_edge` → `IDLE`, with no further pulse.
  - With the macro, see Configuration.
- `WAIT2` (`held`=0), counter increments each cycle.
  - `p_edge` → `double_click` pulse, go to `PRESS2`.
  - Otherwise, counter = `DBL_GAP_CYCLES`-1 → `short_press` pulse, go to `IDLE`.
  - `p_edge` has priority over the timeout on the same edge.
- `PRESS2` (`held`=1)
  - `n_edge` → `IDLE`.
  - Press duration is not timed: no long press is generated from the second press.
- Exactly one of `short_press`, `long_press` or `double_click` is produced per interaction.
- `reset_p` asserted mid-interaction: return to `IDLE` immediately. No pending event is emitted. A release after reset deasserts is ignored.

## Timing
- Event pulses are high for exactly one cycle.
- `double_click` is high in the cycle after the edge that samples the second `p_edge`.
- `long_press` is high after the `LONG_CYCLES`-th rising edge following the edge that sampled `p_edge`.
- `short_press` is high after the `DBL_GAP_CYCLES`-th rising edge following the edge that sampled `n_edge`.
- `held` updates in the same cycle as the state register, i.e. one cycle after the sampled edge pulse.
- A second `p_edge` arriving exactly `DBL_GAP_CYCLES` cycles after `n_edge` coincides with the timeout and counts as a double click. One cycle later, it yields `short_press` and is ignored, because it arrives while in `IDLE` after the pulse edge.

## Configuration
- Macro: `BTN_PRESS_REPEAT_EN`.
- Defined:
  - In `LONG_HELD`, the counter runs.
  - Each time it reaches `REPEAT_CYCLES`-1, `repeat_pulse` fires for one cycle and the counter clears.
  - First repeat: `REPEAT_CYCLES` cycles after `long_press`.
  - `n_edge` stops repeats immediately; no repeat fires on the release edge.
- Undefined:
  - `repeat_pulse` is tied to 0 and the repeat counter logic is absent.
  - `REPEAT_CYCLES` is unused.

## Test plan
Bench parameters: `LONG_CYCLES`=20, `DBL_GAP_CYCLES`=10, `REPEAT_CYCLES`=5.
- Press 5 cycles, then release → single `short_press` 10 cycles after the `n_edge` sample. No other pulses; `held` is high for 5 cycles.
- Hold 32 cycles → `long_press` 20 cycles after `p_edge`.
  - With macro: `repeat_pulse` at +25 and +30.
  - Release → no `short_press`.
- Press 3, release, press again 4 cycles later, hold 8, release → `double_click` 1 cycle after the second `p_edge`. No `short_press`, no `long_press`.
- Release, then second `p_edge` exactly 10 cycles after `n_edge` → `double_click`. Repeat the test with 11 cycles → `short_press` only.
- Assert `reset_p` mid-`PRESS1` (cycle 7), deassert, then pulse `n_edge` → all outputs 0; state `IDLE` throughout.
- `p_edge` and `n_edge` high together in `IDLE` and in `PRESS1` → no state change and no pulses.
